// File: rtl/pipe_demux.sv
`default_nettype none
// ============================================================================
// Module      : pipe_demux
// Description : Registered 1-to-2 demultiplexer for a valid/ready word stream.
//               Each accepted word is routed by in_sel into one of two output
//               buffers. Each buffer has its own valid/ready handshake, so a
//               stalled consumer never blocks words bound for the other one.
//
//               Optional feature macro: PIPE_DEMUX_SKID_EN
//                 undefined : depth-1 buffers. in_ready has a combinational
//                             path from the selected out ready, which gives
//                             full throughput.
//                 defined   : depth-2 skid buffers (head + tail). in_ready
//                             depends only on registered state.
//
// Ports       : clk, rst_n    rising-edge clock, asynchronous active-low reset
//               flush         synchronous clear of all buffered words
//               in_valid/in_ready/in_sel/in_data   upstream handshake + route
//               out0_valid/out0_ready/out0_data    consumer 0
//               out1_valid/out1_ready/out1_data    consumer 1
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_demux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sel,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out1_data
);

`ifdef PIPE_DEMUX_SKID_EN
    localparam int c_cnt_w = 2;
`else
    localparam int c_cnt_w = 1;
`endif

    // Per-buffer occupancy and head-of-buffer word (index = output number).
    logic [c_cnt_w-1:0]    r_count [2];
    logic [DATA_WIDTH-1:0] r_head  [2];
`ifdef PIPE_DEMUX_SKID_EN
    logic [DATA_WIDTH-1:0] r_tail  [2];
`endif

    logic [1:0] w_out_ready;
    logic [1:0] w_push;
    logic [1:0] w_pop;

    assign w_out_ready = {out1_ready, out0_ready};

    // Acceptance looks only at the buffer selected by in_sel. Reset and flush
    // both force in_ready low so nothing is taken in those cycles.
`ifdef PIPE_DEMUX_SKID_EN
    assign in_ready = rst_n && !flush && (r_count[in_sel] != 2'd2);
`else
    assign in_ready = rst_n && !flush &&
                      ((r_count[in_sel] == 1'b0) || w_out_ready[in_sel]);
`endif

    always_comb begin
        w_push         = 2'b00;
        w_push[in_sel] = in_valid && in_ready;
        // A pop in a flush cycle is void; the buffer is cleared instead.
        w_pop[0]       = (r_count[0] != '0) && out0_ready && !flush;
        w_pop[1]       = (r_count[1] != '0) && out1_ready && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_count[i] <= '0;
                r_head[i]  <= '0;
`ifdef PIPE_DEMUX_SKID_EN
                r_tail[i]  <= '0;
`endif
            end
        end else if (flush) begin
            for (int i = 0; i < 2; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
`ifdef PIPE_DEMUX_SKID_EN
                case ({w_push[i], w_pop[i]})
                    2'b10: begin
                        if (r_count[i] == 2'd0) begin
                            r_head[i] <= in_data;
                        end else begin
                            r_tail[i] <= in_data;
                        end
                        r_count[i] <= r_count[i] + 2'd1;
                    end
                    2'b01: begin
                        if (r_count[i] == 2'd2) begin
                            r_head[i] <= r_tail[i];
                        end
                        r_count[i] <= r_count[i] - 2'd1;
                    end
                    2'b11: begin
                        // Only reachable at count 1 (count 2 blocks the push,
                        // count 0 has nothing to pop): replace the head.
                        r_head[i] <= in_data;
                    end
                    default: begin
                    end
                endcase
`else
                // Push wins: with a simultaneous pop the old head leaves and
                // the new word takes its place, count stays at 1.
                if (w_push[i]) begin
                    r_head[i]  <= in_data;
                    r_count[i] <= 1'b1;
                end else if (w_pop[i]) begin
                    r_count[i] <= 1'b0;
                end
`endif
            end
        end
    end

    assign out0_valid = (r_count[0] != '0);
    assign out1_valid = (r_count[1] != '0);
    assign out0_data  = r_head[0];
    assign out1_data  = r_head[1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_demux
// Description : Self-checking bench for pipe_demux. A scoreboard keeps one
//               queue of expected words per output; its occupancy also gives
//               the expected in_ready and outX_valid every cycle. Scenario
//               tasks add their own targeted checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_demux;

`ifdef PIPE_DEMUX_SKID_EN
    localparam int c_depth = 2;
`else
    localparam int c_depth = 1;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        flush      = 1'b0;
    logic        in_valid   = 1'b0;
    logic        in_sel     = 1'b0;
    logic [31:0] in_data    = 32'h0;
    logic        out0_ready = 1'b0;
    logic        out1_ready = 1'b0;
    logic        in_ready;
    logic        out0_valid;
    logic        out1_valid;
    logic [31:0] out0_data;
    logic [31:0] out1_data;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    pipe_demux #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    always #5 clk = ~clk;

    // Scoreboard: evaluated mid-cycle, predicts what the next rising edge does.
    always @(negedge clk) begin : sb
        int   sz;
        logic rdy_sel;
        logic exp_ready;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else if (mon_en) begin
            sz      = in_sel ? q1.size() : q0.size();
            rdy_sel = in_sel ? out1_ready : out0_ready;
            if (c_depth == 2) exp_ready = !flush && (sz < 2);
            else              exp_ready = !flush && ((sz == 0) || rdy_sel);

            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL sb_in_ready: got %b expected %b (sel=%b) t=%0t", in_ready, exp_ready, in_sel, $time);
            end
            checks++;
            if (out0_valid !== (q0.size() != 0)) begin
                errors++;
                $display("FAIL sb_out0_valid: got %b expected %b t=%0t", out0_valid, (q0.size() != 0), $time);
            end
            checks++;
            if (out1_valid !== (q1.size() != 0)) begin
                errors++;
                $display("FAIL sb_out1_valid: got %b expected %b t=%0t", out1_valid, (q1.size() != 0), $time);
            end
            if (q0.size() != 0) begin
                checks++;
                if (out0_data !== q0[0]) begin
                    errors++;
                    $display("FAIL sb_out0_data: got %h expected %h t=%0t", out0_data, q0[0], $time);
                end
            end
            if (q1.size() != 0) begin
                checks++;
                if (out1_data !== q1[0]) begin
                    errors++;
                    $display("FAIL sb_out1_data: got %h expected %h t=%0t", out1_data, q1[0], $time);
                end
            end

            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (q0.size() != 0 && out0_ready) void'(q0.pop_front());
                if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
                if (in_valid && exp_ready) begin
                    if (in_sel) q1.push_back(in_data);
                    else        q0.push_back(in_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d words left expected 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_reset_state();
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got %b%b expected 00", out1_valid, out0_valid);
        end
        checks++;
        if (out0_data !== 32'h0 || out1_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h expected 0/0", out0_data, out1_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
    endtask

    task automatic test_reset();
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rst_preload: got %b/%h expected 1/deadbeef", out0_valid, out0_data);
        end
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out0_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_async_clear: got %b/%h expected 0/00000000", out0_valid, out0_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready_low: got %b expected 0", in_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_routing();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h11111111;
        step();
        in_sel  = 1'b1;
        in_data = 32'h22222222;
        @(negedge clk);
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h11111111) begin
            errors++;
            $display("FAIL route_out0: got %b/%h expected 1/11111111", out0_valid, out0_data);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h22222222) begin
            errors++;
            $display("FAIL route_out1: got %b/%h expected 1/22222222", out1_valid, out1_data);
        end
        drain();
    endtask

    task automatic test_stall();
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        for (int i = 0; i < c_depth; i++) begin
            in_data = 32'h30000000 + i;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_fill_ready: got %b expected 1 (word %0d)", in_ready, i);
            end
            step();
        end
        in_data = 32'h3000FFFF;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full_ready: got %b expected 0", in_ready);
        end
        step();
        in_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h40000000 + i;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_other_flow: got %b expected 1 (word %0d)", in_ready, i);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h30000000) begin
            errors++;
            $display("FAIL stall_out0_held: got %b/%h expected 1/30000000", out0_valid, out0_data);
        end
        drain();
    endtask

`ifdef PIPE_DEMUX_SKID_EN
    task automatic test_skid_order();
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h1;
        step();
        in_data = 32'h2;
        step();
        in_valid = 1'b0;
        out0_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_ready_indep: got %b expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out0_data !== 32'h1) begin
            errors++;
            $display("FAIL skid_first: got %h expected 00000001", out0_data);
        end
        @(negedge clk);
        checks++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h2) begin
            errors++;
            $display("FAIL skid_second: got %b/%h expected 1/00000002", out0_valid, out0_data);
        end
        @(negedge clk);
        checks++;
        if (out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_empty: got %b expected 0", out0_valid);
        end
        drain();
    endtask
`else
    task automatic test_full_throughput();
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 32'h5A5A0001;
        step();
        out1_ready = 1'b1;
        in_data    = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out1_valid !== 1'b1) begin
            errors++;
            $display("FAIL thru_accept: got ready=%b valid=%b expected 1/1", in_ready, out1_valid);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL thru_data: got %b/%h expected 1/a5a5a5a5", out1_valid, out1_data);
        end
        drain();
    endtask
`endif

    task automatic test_flush();
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'h0F0F0001;
        step();
        in_sel  = 1'b1;
        in_data = 32'h0F0F0002;
        step();
        flush      = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hBADBAD00;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_valids: got %b%b expected 00 (cycle %0d)", out1_valid, out0_valid, i);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_sel     = $urandom_range(0, 1) == 1;
            in_data    = $urandom;
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0;
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        test_reset_state();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        test_reset();
        test_routing();
        test_stall();
`ifdef PIPE_DEMUX_SKID_EN
        test_skid_order();
`else
        test_full_throughput();
`endif
        test_flush();
        test_back_to_back();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
